// File: rtl/spi_master_core.sv
`default_nettype none
//==============================================================================
// Module      : spi_master_core
// Description : SPI master engine. TX/RX byte FIFOs, programmable prescaler,
//               CPOL/CPHA/bit order, busy flag and level interrupt.
// Revision    : 1.0 - initial release
//==============================================================================
module spi_master_core #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wrdata,
    input  logic       wr_txfifo,
    input  logic       rd_rxfifo,
    input  logic       spi_en,
    input  logic       irq_en,
    input  logic [3:0] psc,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       firstbit,
    input  logic       MISO,
    output logic       CS_N,
    output logic       SCK,
    output logic       MOSI,
    output logic [7:0] rddata,
    output logic       tr_flag,
    output logic       irq
);

    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0] c_DEPTH = (c_AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TRAIL = 2'd3
    } state_t;

    // Select bit number idx of the transmit order from a byte.
    function automatic logic f_bitsel(input logic [7:0] b, input logic [2:0] idx, input logic lsb);
        return lsb ? b[idx] : b[3'd7 - idx];
    endfunction

    // ---------------- FIFO storage and pointers ----------------
    logic [7:0]      r_tx_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_tx_wp, r_tx_rp;
    logic [c_AW:0]   r_tx_cnt;
    logic [7:0]      r_rx_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_rx_wp, r_rx_rp;
    logic [c_AW:0]   r_rx_cnt;

    // ---------------- FSM registers ----------------
    state_t     r_state;
    logic [3:0] r_cnt;      // cycles elapsed in the current half-period
    logic [3:0] r_edge;     // SCK toggles already made in this byte
    logic [7:0] r_tx_sh;
    logic [7:0] r_rx;
    logic [3:0] r_psc;
    logic       r_cpol, r_cpha, r_lsb;
    logic       r_cs_n, r_sck, r_mosi;
    logic       r_tr_flag, r_irq;

    // ---------------- Combinational control ----------------
    logic       w_tx_push, w_tx_avail, w_load;
    logic       w_tick, w_last, w_odd, w_sample, w_drive;
    logic [2:0] w_drive_idx, w_rx_pos;
    logic [7:0] w_rx_next, w_tx_head;
    logic       w_rx_push, w_rx_pop, w_rx_wr;

    assign w_tx_head   = r_tx_mem[r_tx_rp];
    assign w_tx_push   = wr_txfifo && (r_tx_cnt != c_DEPTH);
    assign w_tx_avail  = spi_en && (r_tx_cnt != '0);
    assign w_tick      = (r_cnt == r_psc);
    assign w_last      = (r_edge == 4'd15);
    // Edge number k = r_edge+1, so k is odd (leading) when r_edge is even.
    assign w_odd       = ~r_edge[0];
    assign w_sample    = (r_state == ST_SHIFT) && w_tick && (r_cpha ? ~w_odd : w_odd);
    assign w_drive     = (r_state == ST_SHIFT) && w_tick && (r_cpha ? w_odd : (~w_odd && !w_last));
    assign w_drive_idx = r_cpha ? r_edge[3:1] : (r_edge[3:1] + 3'd1);
    assign w_rx_pos    = r_lsb ? r_edge[3:1] : (3'd7 - r_edge[3:1]);
    assign w_rx_push   = (r_state == ST_SHIFT) && w_tick && w_last;
    assign w_load      = w_tx_avail && ((r_state == ST_IDLE) || w_rx_push);
    assign w_rx_pop    = rd_rxfifo && (r_rx_cnt != '0);
    assign w_rx_wr     = w_rx_push && ((r_rx_cnt != c_DEPTH) || w_rx_pop);

    // Received byte including the bit sampled in this cycle (edge 16 for cpha=1).
    always_comb begin
        w_rx_next = r_rx;
        if (w_sample) begin
            w_rx_next[w_rx_pos] = MISO;
        end
    end

    // TX FIFO data array; flushing is done through the pointers.
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wp] <= wrdata;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_load)    r_tx_rp <= r_tx_rp + 1'b1;
            case ({w_tx_push, w_load})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // RX FIFO data array.
    always_ff @(posedge clk) begin
        if (w_rx_wr) begin
            r_rx_mem[r_rx_wp] <= w_rx_next;
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_wr)  r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
            case ({w_rx_wr, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // Transfer FSM: byte load, half-period timing, SCK/MOSI/CS_N generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_edge  <= '0;
            r_tx_sh <= '0;
            r_rx    <= '0;
            r_psc   <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            r_cs_n  <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_sck  <= cpol;
                    r_cs_n <= 1'b1;
                    if (w_tx_avail) begin
                        r_tx_sh <= w_tx_head;
                        r_psc   <= psc;
                        r_cpol  <= cpol;
                        r_cpha  <= cpha;
                        r_lsb   <= firstbit;
                        r_cnt   <= '0;
                        r_edge  <= '0;
                        r_rx    <= '0;
                        r_cs_n  <= 1'b0;
                        if (!cpha) r_mosi <= f_bitsel(w_tx_head, 3'd0, firstbit);
                        r_state <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_SHIFT: begin
                    r_rx <= w_rx_next;
                    if (w_tick) begin
                        r_cnt  <= '0;
                        r_sck  <= ~r_sck;
                        r_edge <= r_edge + 4'd1;
                        if (w_drive) r_mosi <= f_bitsel(r_tx_sh, w_drive_idx, r_lsb);
                        if (w_last) begin
                            if (w_tx_avail) begin
                                // Back-to-back byte: no LEAD, CS_N stays low.
                                r_tx_sh <= w_tx_head;
                                r_psc   <= psc;
                                r_cpol  <= cpol;
                                r_cpha  <= cpha;
                                r_lsb   <= firstbit;
                                r_edge  <= '0;
                                r_rx    <= '0;
                                if (!cpha) r_mosi <= f_bitsel(w_tx_head, 3'd0, firstbit);
                            end else begin
                                r_state <= ST_TRAIL;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_TRAIL: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_cs_n  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Registered busy flag and level interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tr_flag <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_tr_flag <= (r_state != ST_IDLE) || (r_tx_cnt != '0);
            r_irq     <= irq_en && (r_rx_cnt != '0);
        end
    end

    assign CS_N    = r_cs_n;
    assign SCK     = r_sck;
    assign MOSI    = r_mosi;
    assign tr_flag = r_tr_flag;
    assign irq     = r_irq;
    assign rddata  = (r_rx_cnt != '0) ? r_rx_mem[r_rx_rp] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_core.sv
`default_nettype none
//==============================================================================
// Module      : tb_spi_master_core
// Description : Directed self-checking bench for spi_master_core.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_spi_master_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wrdata;
    logic       wr_txfifo, rd_rxfifo, spi_en, irq_en;
    logic [3:0] psc;
    logic       cpol, cpha, firstbit;
    logic       MISO;
    logic       CS_N, SCK, MOSI, tr_flag, irq;
    logic [7:0] rddata;

    int checks   = 0;
    int failures = 0;

    // Measurement results
    int m_cs, m_tog, m_mosi_hi, m_gmin, m_gmax;

    // Slave model for non-loopback tests
    logic       loopb;
    logic [7:0] pat;
    logic       m_miso;
    logic       m_last_sck;
    int         m_edge;

    assign MISO = loopb ? MOSI : m_miso;

    always #5 clk = ~clk;

    spi_master_core #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .wrdata(wrdata), .wr_txfifo(wr_txfifo),
        .rd_rxfifo(rd_rxfifo), .spi_en(spi_en), .irq_en(irq_en), .psc(psc),
        .cpol(cpol), .cpha(cpha), .firstbit(firstbit), .MISO(MISO),
        .CS_N(CS_N), .SCK(SCK), .MOSI(MOSI), .rddata(rddata),
        .tr_flag(tr_flag), .irq(irq)
    );

    // MSB-first slave: drives on its drive edge, corrupts MISO right after the
    // master's sampling edge so wrong-edge sampling reads inverted bits.
    always @(SCK or CS_N) begin
        if (CS_N !== 1'b0) begin
            m_edge = 0;
            m_miso = pat[7];
        end else if (SCK !== m_last_sck) begin
            m_edge = m_edge + 1;
            if (!cpha) begin
                if (m_edge % 2 == 1)  m_miso = ~m_miso;
                else if (m_edge < 16) m_miso = pat[7 - m_edge/2];
            end else begin
                if (m_edge % 2 == 1)  m_miso = pat[7 - (m_edge-1)/2];
                else                  m_miso = ~m_miso;
            end
        end
        m_last_sck = SCK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        @(negedge clk);
        wrdata    = b;
        wr_txfifo = 1'b1;
        @(negedge clk);
        wr_txfifo = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        rd_rxfifo = 1'b1;
        @(negedge clk);
        rd_rxfifo = 1'b0;
    endtask

    // Follow one CS_N-low window; optionally clear spi_en or assert reset
    // right after a given SCK toggle count.
    task automatic measure(input int clr_at, input int rst_at);
        int   t, prev_t;
        logic prev_sck;
        m_cs = 0; m_tog = 0; m_mosi_hi = 0; m_gmin = 1000; m_gmax = 0;
        t = 0;
        while (CS_N !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (CS_N !== 1'b0) begin
            chk("cs_fall_timeout", {31'd0, CS_N}, 32'd0);
            return;
        end
        prev_sck = SCK; prev_t = 0; t = 0;
        while (CS_N === 1'b0 && t < 5000) begin
            m_cs++;
            if (MOSI === 1'b1) m_mosi_hi++;
            @(negedge clk);
            t++;
            if (SCK !== prev_sck) begin
                m_tog++;
                if (m_tog > 1) begin
                    if (t - prev_t < m_gmin) m_gmin = t - prev_t;
                    if (t - prev_t > m_gmax) m_gmax = t - prev_t;
                end
                prev_t   = t;
                prev_sck = SCK;
                if (m_tog == clr_at) spi_en = 1'b0;
                if (m_tog == rst_at) begin
                    rst = 1'b1;
                    return;
                end
            end
        end
        if (CS_N === 1'b0) chk("cs_rise_timeout", {31'd0, CS_N}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; wrdata = '0; wr_txfifo = 0; rd_rxfifo = 0; spi_en = 0;
        irq_en = 0; psc = 0; cpol = 0; cpha = 0; firstbit = 0;
        loopb = 1'b1; pat = 8'h3C; m_miso = 0; m_last_sck = 0; m_edge = 0;

        // ---- Reset values ----
        repeat (2) @(negedge clk);
        chk("rst_cs_n",   {31'd0, CS_N},    32'd1);
        chk("rst_sck",    {31'd0, SCK},     32'd0);
        chk("rst_mosi",   {31'd0, MOSI},    32'd0);
        chk("rst_rddata", {24'd0, rddata},  32'd0);
        chk("rst_trflag", {31'd0, tr_flag}, 32'd0);
        chk("rst_irq",    {31'd0, irq},     32'd0);
        rst = 1'b0;

        // ---- Loopback 0xA5, mode 0, psc=0 ----
        irq_en = 1; spi_en = 1;
        @(negedge clk);
        wr(8'hA5);
        chk("lat_cs_hi_1cyc", {31'd0, CS_N}, 32'd1);
        @(negedge clk);
        chk("lat_cs_lo_2cyc", {31'd0, CS_N}, 32'd0);
        measure(0, 0);
        chk("a5_cs_low",  m_cs,   32'd18);
        chk("a5_toggles", m_tog,  32'd16);
        chk("a5_gapmin",  m_gmin, 32'd1);
        chk("a5_gapmax",  m_gmax, 32'd1);
        chk("a5_rddata",  {24'd0, rddata}, 32'hA5);
        repeat (2) @(negedge clk);
        chk("a5_trflag",  {31'd0, tr_flag}, 32'd0);
        chk("a5_irq",     {31'd0, irq},     32'd1);
        pop();
        chk("a5_rd_empty", {24'd0, rddata}, 32'd0);
        @(negedge clk);
        chk("a5_irq_clr", {31'd0, irq}, 32'd0);

        // ---- All four modes, psc=3, slave returns 0x3C ----
        for (int m = 0; m < 4; m++) begin
            loopb = 1'b0;
            cpol = m[1]; cpha = m[0]; psc = 4'd3;
            repeat (3) @(negedge clk);
            chk($sformatf("m%0d_sck_idle", m), {31'd0, SCK}, {31'd0, cpol});
            wr(8'h00);
            measure(0, 0);
            chk($sformatf("m%0d_cs_low", m),  m_cs,   32'd72);
            chk($sformatf("m%0d_toggles", m), m_tog,  32'd16);
            chk($sformatf("m%0d_gapmin", m),  m_gmin, 32'd4);
            chk($sformatf("m%0d_gapmax", m),  m_gmax, 32'd4);
            repeat (2) @(negedge clk);
            chk($sformatf("m%0d_sck_end", m), {31'd0, SCK}, {31'd0, cpol});
            chk($sformatf("m%0d_rddata", m),  {24'd0, rddata}, 32'h3C);
            pop();
        end
        loopb = 1'b1; cpol = 0; cpha = 0; psc = 0;
        repeat (3) @(negedge clk);

        // ---- FIFO depth: 6 writes, 4 kept, back-to-back ----
        spi_en = 0;
        for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i));
        @(negedge clk);
        chk("ff_trflag_q", {31'd0, tr_flag}, 32'd1);
        chk("ff_cs_idle",  {31'd0, CS_N},    32'd1);
        spi_en = 1;
        measure(0, 0);
        chk("ff_cs_low",  m_cs,   32'd66);
        chk("ff_toggles", m_tog,  32'd64);
        chk("ff_gapmax",  m_gmax, 32'd1);
        repeat (2) @(negedge clk);
        chk("ff_trflag_0", {31'd0, tr_flag}, 32'd0);
        chk("ff_irq",      {31'd0, irq},     32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ff_rd%0d", i), {24'd0, rddata}, 32'h10 + i);
            pop();
        end
        chk("ff_rd_empty", {24'd0, rddata}, 32'd0);
        pop();
        chk("ff_rd_5th", {24'd0, rddata}, 32'd0);
        @(negedge clk);
        chk("ff_irq_clr", {31'd0, irq}, 32'd0);

        // ---- spi_en cleared mid-byte with two bytes queued ----
        spi_en = 0;
        wr(8'h81); wr(8'h42); wr(8'h99);
        spi_en = 1;
        measure(5, 0);
        chk("en_cs_low",  m_cs,  32'd18);
        chk("en_toggles", m_tog, 32'd16);
        repeat (3) @(negedge clk);
        chk("en_trflag_1", {31'd0, tr_flag}, 32'd1);
        chk("en_cs_hi",    {31'd0, CS_N},    32'd1);
        chk("en_rddata",   {24'd0, rddata},  32'h81);
        spi_en = 1;
        measure(0, 0);
        chk("en2_cs_low",  m_cs,  32'd34);
        chk("en2_toggles", m_tog, 32'd32);
        repeat (3) @(negedge clk);
        chk("en2_trflag_0", {31'd0, tr_flag}, 32'd0);
        chk("en2_rd0", {24'd0, rddata}, 32'h81); pop();
        chk("en2_rd1", {24'd0, rddata}, 32'h42); pop();
        chk("en2_rd2", {24'd0, rddata}, 32'h99); pop();

        // ---- firstbit=1 loopback 0x01 (left in RX for the reset test) ----
        firstbit = 1;
        @(negedge clk);
        wr(8'h01);
        measure(0, 0);
        chk("lsb_mosi_hi", m_mosi_hi, 32'd3);
        chk("lsb_cs_low",  m_cs,      32'd18);
        repeat (2) @(negedge clk);
        chk("lsb_rddata", {24'd0, rddata}, 32'h01);
        chk("lsb_irq",    {31'd0, irq},    32'd1);

        // ---- Reset at edge 7 ----
        firstbit = 0;
        wr(8'h5A);
        measure(0, 7);
        chk("rs_edge_reached", m_tog, 32'd7);
        #1;
        chk("rs_cs_n",   {31'd0, CS_N},    32'd1);
        chk("rs_sck",    {31'd0, SCK},     32'd0);
        chk("rs_trflag", {31'd0, tr_flag}, 32'd0);
        chk("rs_irq",    {31'd0, irq},     32'd0);
        chk("rs_rddata", {24'd0, rddata},  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("rs_post_cs",     {31'd0, CS_N},    32'd1);
        chk("rs_post_rddata", {24'd0, rddata},  32'd0);
        chk("rs_post_irq",    {31'd0, irq},     32'd0);
        chk("rs_post_trflag", {31'd0, tr_flag}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
